// File: rtl/fusion_pkg.sv
// Shared constants and types for the fusible bit-brick MAC cell.
package fusion_pkg;

    localparam logic [2:0] BW_2 = 3'b001;
    localparam logic [2:0] BW_4 = 3'b010;
    localparam logic [2:0] BW_8 = 3'b100;

    localparam int NUM_BRICKS = 16;
    localparam int SLICE_W    = 2;
    localparam int BUS_W      = NUM_BRICKS * SLICE_W;
    localparam int PSUM_W     = 32;
    localparam int PROD_W     = 18;  // 6b product shifted by up to 12

    // Per-brick operand routing derived from the width/sign fields.
    typedef struct packed {
        logic [1:0] i_idx;   // input slice position within its operand
        logic [1:0] j_idx;   // weight slice position within its operand
        logic       i_sext;  // input slice is a signed MSB slice
        logic       w_sext;  // weight slice is a signed MSB slice
    } brick_cfg_t;

    // log2 of slices per operand; unknown codes fall back to 8b.
    function automatic logic [1:0] bw_log2(input logic [2:0] bw);
        case (bw)
            BW_2:    return 2'd0;
            BW_4:    return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    // (1 << lg) - 1 as a 4-bit mask, lg in 0..4.
    function automatic logic [3:0] lg_mask(input logic [2:0] lg);
        return 4'((5'd1 << lg) - 5'd1);
    endfunction

endpackage

// File: rtl/fusion_unit_core_bit_brick.sv
// One 2x2-bit brick: extends each slice to 3b, multiplies signed,
// and places the product at bit weight 2*(i+j).
module bit_brick
    import fusion_pkg::*;
(
    input  logic [SLICE_W-1:0]       in_slice,
    input  logic [SLICE_W-1:0]       w_slice,
    input  logic                     in_sext,
    input  logic                     w_sext,
    input  logic [1:0]               i_idx,
    input  logic [1:0]               j_idx,
    output logic signed [PROD_W-1:0] prod
);

    logic signed [5:0] a6;
    logic signed [5:0] b6;
    logic signed [5:0] p6;
    logic        [2:0] sh;

    // Extend slices, multiply, and shift into place.
    always_comb begin
        a6   = {{4{in_sext & in_slice[1]}}, in_slice};
        b6   = {{4{w_sext & w_slice[1]}}, w_slice};
        p6   = a6 * b6;
        sh   = {1'b0, i_idx} + {1'b0, j_idx};
        prod = {{(PROD_W-6){p6[5]}}, p6} <<< {sh, 1'b0};
    end

endmodule

// File: rtl/fusion_unit_core.sv
// Fusible MAC cell: decodes operand widths into brick routing, sums the
// sixteen shifted brick products into a registered psum and forwards the
// input bus one cell to the right.
module fusion_unit_core
    import fusion_pkg::*;
(
    input  logic              clk,
    input  logic              nRST,
    input  logic [2:0]        input_bitwidth,
    input  logic [2:0]        weight_bitwidth,
    input  logic [3:0]        input_sign,
    input  logic [3:0]        weight_sign,
    input  logic [BUS_W-1:0]  input_forward,
    input  logic [BUS_W-1:0]  weight,
    output logic [PSUM_W-1:0] psum,
    output logic [BUS_W-1:0]  input_to_right
);

    brick_cfg_t [NUM_BRICKS-1:0]             cfg;
    logic       [NUM_BRICKS-1:0][PROD_W-1:0] prod;
    logic       [1:0]                        ni_lg;
    logic       [1:0]                        nw_lg;
    logic       [3:0]                        g_mask;
    logic       [3:0]                        ni_mask;
    logic       [3:0]                        nw_mask;
    logic       [PSUM_W-1:0]                 psum_d,  psum_q;
    logic       [BUS_W-1:0]                  itr_d,   itr_q;

    // Map each brick to its slice pair: l = k mod G, i = l / Nw, j = l mod Nw.
    always_comb begin
        ni_lg   = bw_log2(input_bitwidth);
        nw_lg   = bw_log2(weight_bitwidth);
        g_mask  = lg_mask({1'b0, ni_lg} + {1'b0, nw_lg});
        ni_mask = lg_mask({1'b0, ni_lg});
        nw_mask = lg_mask({1'b0, nw_lg});
        cfg     = '0;
        for (int k = 0; k < NUM_BRICKS; k++) begin
            cfg[k].i_idx  = 2'((4'(k) & g_mask) >> nw_lg);
            cfg[k].j_idx  = 2'(4'(k) & nw_mask);
            cfg[k].i_sext = input_sign[k/4]  && (cfg[k].i_idx == ni_mask[1:0]);
            cfg[k].w_sext = weight_sign[k/4] && (cfg[k].j_idx == nw_mask[1:0]);
        end
    end

    for (genvar k = 0; k < NUM_BRICKS; k++) begin : g_brick
        bit_brick u_brick (
            .in_slice (input_forward[SLICE_W*k +: SLICE_W]),
            .w_slice  (weight[SLICE_W*k +: SLICE_W]),
            .in_sext  (cfg[k].i_sext),
            .w_sext   (cfg[k].w_sext),
            .i_idx    (cfg[k].i_idx),
            .j_idx    (cfg[k].j_idx),
            .prod     (prod[k])
        );
    end

    // Sign-extend and sum all brick products; forward the input bus.
    always_comb begin
        psum_d = '0;
        for (int k = 0; k < NUM_BRICKS; k++) begin
            psum_d = psum_d + {{(PSUM_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
        end
        itr_d = input_forward;
    end

    // Output registers; reset wins over fresh data.
    always_ff @(posedge clk) begin
        if (nRST) begin
            psum_q <= '0;
            itr_q  <= '0;
        end else begin
            psum_q <= psum_d;
            itr_q  <= itr_d;
        end
    end

    assign psum           = psum_q;
    assign input_to_right = itr_q;

endmodule

// File: tb/tb_fusion_unit_core.sv
// Directed bench for fusion_unit_core with hand-computed expected values.
module tb_fusion_unit_core;

    logic        clk = 1'b0;
    logic        nRST;
    logic [2:0]  input_bitwidth;
    logic [2:0]  weight_bitwidth;
    logic [3:0]  input_sign;
    logic [3:0]  weight_sign;
    logic [31:0] input_forward;
    logic [31:0] weight;
    logic [31:0] psum;
    logic [31:0] input_to_right;

    int checks = 0;
    int errors = 0;

    fusion_unit_core dut (
        .clk             (clk),
        .nRST            (nRST),
        .input_bitwidth  (input_bitwidth),
        .weight_bitwidth (weight_bitwidth),
        .input_sign      (input_sign),
        .weight_sign     (weight_sign),
        .input_forward   (input_forward),
        .weight          (weight),
        .psum            (psum),
        .input_to_right  (input_to_right)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] ibw, input logic [2:0] wbw,
                         input logic [3:0] is, input logic [3:0] ws,
                         input logic [31:0] inf, input logic [31:0] w);
        input_bitwidth  = ibw;
        weight_bitwidth = wbw;
        input_sign      = is;
        weight_sign     = ws;
        input_forward   = inf;
        weight          = w;
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nRST = 1'b1;
        drive(3'b100, 3'b100, 4'h0, 4'h0, 32'h0000_00FF, 32'h0707_0707);

        // Reset held for two edges with live inputs.
        tick();
        chk("rst0_psum", psum, 32'd0);
        chk("rst0_itr",  input_to_right, 32'd0);
        tick();
        chk("rst1_psum", psum, 32'd0);
        chk("rst1_itr",  input_to_right, 32'd0);

        // 8x8 unsigned 3*7, first edge after release.
        nRST = 1'b0;
        tick();
        chk("u8_3x7_psum", psum, 32'd21);
        chk("u8_3x7_itr",  input_to_right, 32'h0000_00FF);

        // 8x8 unsigned 13*10, no accumulation.
        drive(3'b100, 3'b100, 4'h0, 4'h0, 32'h0000_FF55, 32'h0A0A_0A0A);
        tick();
        chk("u8_13x10_psum", psum, 32'd130);
        chk("u8_13x10_itr",  input_to_right, 32'h0000_FF55);

        // 8x8 signed input -128 * unsigned 255.
        drive(3'b100, 3'b100, 4'hF, 4'h0, 32'hAA00_0000, 32'hFFFF_FFFF);
        tick();
        chk("s8_m128x255_psum", psum, 32'hFFFF_8080);
        chk("s8_m128x255_itr",  input_to_right, 32'hAA00_0000);

        // 2x2 mode, unsigned weights: 16 * (1*3).
        drive(3'b001, 3'b001, 4'h0, 4'h0, 32'h5555_5555, 32'hFFFF_FFFF);
        tick();
        chk("u2_psum", psum, 32'd48);
        chk("u2_itr",  input_to_right, 32'h5555_5555);

        // 2x2 mode, signed weights: 16 * (1*-1).
        drive(3'b001, 3'b001, 4'h0, 4'hF, 32'h5555_5555, 32'hFFFF_FFFF);
        tick();
        chk("s2_psum", psum, 32'hFFFF_FFF0);

        // 8b input x 2b weight: four copies of 200*3.
        drive(3'b100, 3'b001, 4'h0, 4'h0, 32'hC8C8_C8C8, 32'hFFFF_FFFF);
        tick();
        chk("u8x2_psum", psum, 32'd2400);
        chk("u8x2_itr",  input_to_right, 32'hC8C8_C8C8);

        // Illegal width codes decode as 8b: 3*7 again.
        drive(3'b000, 3'b111, 4'h0, 4'h0, 32'h0000_00FF, 32'h0707_0707);
        tick();
        chk("badcode_psum", psum, 32'd21);

        // 4x4 mode: four copies of 5*6.
        drive(3'b010, 3'b010, 4'h0, 4'h0, 32'h5555_5555, 32'h6666_6666);
        tick();
        chk("u4_psum", psum, 32'd120);
        chk("u4_itr",  input_to_right, 32'h5555_5555);

        // Mid-stream reset discards the in-flight result.
        nRST = 1'b1;
        tick();
        chk("midrst_psum", psum, 32'd0);
        chk("midrst_itr",  input_to_right, 32'd0);

        // Release: same inputs produce the product again.
        nRST = 1'b0;
        tick();
        chk("post_rst_psum", psum, 32'd120);
        chk("post_rst_itr",  input_to_right, 32'h5555_5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
